// File: rtl/reg_scoreboard.sv
// Register scoreboard between decode and execute: tracks pending register writes,
// stalls decode on RAW/WAW hazards, and runs a stall watchdog with a sticky timeout.
module reg_scoreboard #(
    parameter int REG_NUM     = 32,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 200,
    parameter int WB_BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid_i,
    input  logic                id_reg1_read_i,
    input  logic [ADDR_W-1:0]   id_reg1_addr_i,
    input  logic                id_reg2_read_i,
    input  logic [ADDR_W-1:0]   id_reg2_addr_i,
    input  logic                id_wreg_i,
    input  logic [ADDR_W-1:0]   id_wd_i,
    input  logic                ex_ready_i,
    input  logic                wb_we_i,
    input  logic [ADDR_W-1:0]   wb_wd_i,
    input  logic                flush_i,
    output logic                issue_o,
    output logic                stall_o,
    output logic [REG_NUM-1:0]  busy_o,
    output logic [ADDR_W:0]     pending_cnt_o,
    output logic [CNT_W-1:0]    stall_cycles_o,
    output logic                timeout_o
);

    typedef enum logic {
        WD_RUN,
        WD_TIMEOUT
    } wd_state_t;

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [ADDR_W:0]    pend_q, pend_d;
    logic [CNT_W-1:0]   stall_q, stall_d, stall_inc;
    wd_state_t          state_q, state_d;

    logic src1_ready, src2_ready, waw_hazard, hazard, issue, stall;

    // A source is ready if it is r0, not pending, or being written back right now.
    function automatic logic src_ready(input logic [ADDR_W-1:0]  a,
                                       input logic [REG_NUM-1:0] busy,
                                       input logic               wb_we,
                                       input logic [ADDR_W-1:0]  wb_wd);
        return (a == '0) || !busy[a] || ((WB_BYPASS != 0) && wb_we && (wb_wd == a));
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [REG_NUM-1:0] v);
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            n = n + (ADDR_W+1)'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        src1_ready = src_ready(id_reg1_addr_i, busy_q, wb_we_i, wb_wd_i);
        src2_ready = src_ready(id_reg2_addr_i, busy_q, wb_we_i, wb_wd_i);
        // WAW ignores the bypass flag: a retiring write frees the slot regardless.
        waw_hazard = id_wreg_i && (id_wd_i != '0) && busy_q[id_wd_i]
                     && !(wb_we_i && (wb_wd_i == id_wd_i));
        hazard     = (id_reg1_read_i && !src1_ready)
                     || (id_reg2_read_i && !src2_ready)
                     || waw_hazard;
        issue      = !rst && id_valid_i && !hazard && ex_ready_i && !flush_i;
        stall      = !rst && id_valid_i && !issue && !flush_i;
    end

    assign issue_o = issue;
    assign stall_o = stall;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (wb_we_i) begin
            busy_d[wb_wd_i] = 1'b0;
        end
        // Set after clear, so a same-cycle retire and re-issue leaves the bit at 1.
        if (issue && id_wreg_i) begin
            busy_d[id_wd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end
        pend_d = popcount(busy_d);
    end

    always_comb begin
        stall_inc = (stall_q == '1) ? stall_q : stall_q + 1'b1;
        stall_d   = stall_q;
        state_d   = state_q;

        // Stalls due only to a busy execute stage hold the count unchanged.
        if (issue || flush_i || !id_valid_i) begin
            stall_d = '0;
        end else if (stall && hazard) begin
            stall_d = stall_inc;
        end

        case (state_q)
            WD_RUN: begin
                if (!flush_i && stall && hazard && (stall_inc == CNT_W'(STALL_LIMIT))) begin
                    state_d = WD_TIMEOUT;
                end
            end
            WD_TIMEOUT: begin
                if (flush_i) begin
                    state_d = WD_RUN;
                end
            end
            default: state_d = WD_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            pend_q  <= '0;
            stall_q <= '0;
            state_q <= WD_RUN;
        end else begin
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            state_q <= state_d;
        end
    end

    assign busy_o         = busy_q;
    assign pending_cnt_o  = pend_q;
    assign stall_cycles_o = stall_q;
    assign timeout_o      = (state_q == WD_TIMEOUT);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard with hand-written sequences for
// the watchdog timeout and mid-operation reset.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wreg_i;
    logic [4:0]  id_reg1_addr_i, id_reg2_addr_i, id_wd_i, wb_wd_i;
    logic        ex_ready_i, wb_we_i, flush_i;
    logic        issue_o, stall_o, timeout_o;
    logic [31:0] busy_o;
    logic [5:0]  pending_cnt_o;
    logic [7:0]  stall_cycles_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .id_wreg_i      (id_wreg_i),
        .id_wd_i        (id_wd_i),
        .ex_ready_i     (ex_ready_i),
        .wb_we_i        (wb_we_i),
        .wb_wd_i        (wb_wd_i),
        .flush_i        (flush_i),
        .issue_o        (issue_o),
        .stall_o        (stall_o),
        .busy_o         (busy_o),
        .pending_cnt_o  (pending_cnt_o),
        .stall_cycles_o (stall_cycles_o),
        .timeout_o      (timeout_o)
    );

    typedef struct {
        logic        valid, r1rd;
        logic [4:0]  r1;
        logic        r2rd;
        logic [4:0]  r2;
        logic        wreg;
        logic [4:0]  wd;
        logic        exr, wbwe;
        logic [4:0]  wbwd;
        logic        flush;
        logic        e_issue, e_stall;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
        logic [7:0]  e_sc;
    } vec_t;

    function automatic vec_t mk(input logic valid, input logic r1rd, input logic [4:0] r1,
                                input logic r2rd, input logic [4:0] r2,
                                input logic wreg, input logic [4:0] wd,
                                input logic exr, input logic wbwe, input logic [4:0] wbwd,
                                input logic flush, input logic e_issue, input logic e_stall,
                                input logic [31:0] e_busy, input logic [5:0] e_cnt,
                                input logic [7:0] e_sc);
        vec_t v;
        v.valid = valid; v.r1rd = r1rd; v.r1 = r1; v.r2rd = r2rd; v.r2 = r2;
        v.wreg = wreg; v.wd = wd; v.exr = exr; v.wbwe = wbwe; v.wbwd = wbwd;
        v.flush = flush; v.e_issue = e_issue; v.e_stall = e_stall;
        v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_sc = e_sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid_i     = v.valid;
        id_reg1_read_i = v.r1rd;
        id_reg1_addr_i = v.r1;
        id_reg2_read_i = v.r2rd;
        id_reg2_addr_i = v.r2;
        id_wreg_i      = v.wreg;
        id_wd_i        = v.wd;
        ex_ready_i     = v.exr;
        wb_we_i        = v.wbwe;
        wb_wd_i        = v.wbwd;
        flush_i        = v.flush;
    endtask

    // Called at posedge+1: drive, check combinational outputs mid-cycle, then registered ones.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        #3;
        check({tag, " issue"}, 32'(issue_o), 32'(v.e_issue));
        check({tag, " stall"}, 32'(stall_o), 32'(v.e_stall));
        @(posedge clk);
        #1;
        check({tag, " busy"}, busy_o, v.e_busy);
        check({tag, " pending"}, 32'(pending_cnt_o), 32'(v.e_cnt));
        check({tag, " stall_cycles"}, 32'(stall_cycles_o), 32'(v.e_sc));
    endtask

    vec_t vecs[$];
    vec_t idle;

    initial begin
        idle = mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0);

        //          vld r1rd r1 r2rd r2 wr wd exr wbwe wbwd fl  iss stl busy          cnt sc
        vecs.push_back(mk(1,0, 0,0, 0,1, 3,1,0, 0,0, 1,0,32'h0000_0008,1,0)); // 0 write r3
        vecs.push_back(mk(1,1, 3,0, 0,0, 0,1,0, 0,0, 0,1,32'h0000_0008,1,1)); // 1 RAW r3
        vecs.push_back(mk(1,1, 3,0, 0,0, 0,1,0, 0,0, 0,1,32'h0000_0008,1,2));
        vecs.push_back(mk(1,1, 3,0, 0,0, 0,1,0, 0,0, 0,1,32'h0000_0008,1,3));
        vecs.push_back(mk(1,1, 3,0, 0,0, 0,1,1, 3,0, 1,0,32'h0000_0000,0,0)); // 4 wb bypass
        vecs.push_back(mk(1,0, 0,0, 0,1, 5,1,0, 0,0, 1,0,32'h0000_0020,1,0)); // 5 write r5
        vecs.push_back(mk(1,0, 0,0, 0,1, 5,1,1, 5,0, 1,0,32'h0000_0020,1,0)); // 6 retire+reissue r5
        vecs.push_back(mk(1,1, 0,1, 0,1, 0,1,0, 0,0, 1,0,32'h0000_0020,1,0)); // 7 r0 only
        vecs.push_back(mk(1,1, 0,1, 0,1, 0,1,1, 0,0, 1,0,32'h0000_0020,1,0)); // 8 r0 with wb r0
        vecs.push_back(mk(1,0, 0,0, 0,1, 1,1,0, 0,0, 1,0,32'h0000_0022,2,0)); // 9 write r1
        vecs.push_back(mk(1,0, 0,0, 0,1, 2,1,0, 0,0, 1,0,32'h0000_0026,3,0)); // 10 write r2
        vecs.push_back(mk(1,0, 0,0, 0,1, 7,1,0, 0,0, 1,0,32'h0000_00a6,4,0)); // 11 write r7
        vecs.push_back(mk(1,0, 0,0, 0,1, 4,1,0, 0,1, 0,0,32'h0000_0000,0,0)); // 12 flush+issue
        vecs.push_back(mk(1,0, 0,0, 0,1, 8,1,0, 0,0, 1,0,32'h0000_0100,1,0)); // 13 write r8
        vecs.push_back(mk(1,1, 8,0, 0,0, 0,1,0, 0,0, 0,1,32'h0000_0100,1,1)); // 14 RAW r8
        vecs.push_back(mk(1,1, 6,0, 0,0, 0,0,0, 0,0, 0,1,32'h0000_0100,1,1)); // 15 ex not ready: hold
        vecs.push_back(mk(1,1, 8,0, 0,0, 0,0,0, 0,0, 0,1,32'h0000_0100,1,2)); // 16 hazard + !ready
        vecs.push_back(mk(0,1, 8,0, 0,0, 0,1,0, 0,0, 0,0,32'h0000_0100,1,0)); // 17 invalid clears
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,1,1, 8,0, 0,0,32'h0000_0000,0,0)); // 18 retire r8
        vecs.push_back(mk(1,0, 0,0, 0,1,10,1,0, 0,0, 1,0,32'h0000_0400,1,0)); // 19 write r10
        vecs.push_back(mk(1,0, 0,0, 0,1,10,1,0, 0,0, 0,1,32'h0000_0400,1,1)); // 20 WAW r10
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,1,1,11,0, 0,0,32'h0000_0400,1,0)); // 21 wb non-busy
        vecs.push_back(mk(1,0, 0,1,10,0, 0,1,0, 0,0, 0,1,32'h0000_0400,1,1)); // 22 RAW src2
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,1,0, 0,1, 0,0,32'h0000_0000,0,0)); // 23 flush
        vecs.push_back(mk(1,0, 0,0, 0,1,12,1,0, 0,0, 1,0,32'h0000_1000,1,0)); // 24 write r12
        vecs.push_back(mk(1,0,12,0, 0,1,13,1,0, 0,0, 1,0,32'h0000_3000,2,0)); // 25 unread busy src
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,1,0, 0,1, 0,0,32'h0000_0000,0,0)); // 26 flush

        // Reset: combinational outputs forced low even with a valid issue presented.
        rst = 1'b1;
        drive(mk(1,0,0,0,0,1,3,1,0,0,0, 0,0,0,0,0));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset issue", 32'(issue_o), 32'd0);
        check("reset stall", 32'(stall_o), 32'd0);
        check("reset busy", busy_o, 32'd0);
        check("reset pending", 32'(pending_cnt_o), 32'd0);
        check("reset stall_cycles", 32'(stall_cycles_o), 32'd0);
        check("reset timeout", 32'(timeout_o), 32'd0);
        drive(idle);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
            check($sformatf("v%0d timeout", i), 32'(timeout_o), 32'd0);
        end

        // Watchdog: hold a RAW hazard on r9 until the limit is reached.
        step(mk(1,0,0,0,0,1,9,1,0,0,0, 1,0,32'h200,1,0), "wd write r9");
        for (int k = 1; k <= 200; k++) begin
            step(mk(1,1,9,0,0,0,0,1,0,0,0, 0,1,32'h200,1,8'(k)), $sformatf("wd k%0d", k));
            if (k == 199) check("wd timeout before limit", 32'(timeout_o), 32'd0);
        end
        check("wd timeout at limit", 32'(timeout_o), 32'd1);
        step(mk(1,1,9,0,0,0,0,1,1,9,0, 1,0,32'h0,0,0), "wd retire r9");
        check("wd timeout sticky after retire", 32'(timeout_o), 32'd1);
        step(mk(1,0,0,0,0,1,14,1,0,0,0, 1,0,32'h4000,1,0), "wd issue in timeout");
        check("wd timeout sticky after issue", 32'(timeout_o), 32'd1);
        step(mk(0,0,0,0,0,0,0,1,0,0,1, 0,0,32'h0,0,0), "wd flush");
        check("wd timeout cleared by flush", 32'(timeout_o), 32'd0);

        // Reset mid-operation wins over a valid issue.
        step(mk(1,0,0,0,0,1,15,1,0,0,0, 1,0,32'h8000,1,0), "rst write r15");
        drive(mk(1,0,0,0,0,1,16,1,0,0,0, 0,0,0,0,0));
        rst = 1'b1;
        #3;
        check("midrst issue", 32'(issue_o), 32'd0);
        check("midrst stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        check("midrst busy", busy_o, 32'd0);
        check("midrst pending", 32'(pending_cnt_o), 32'd0);
        check("midrst timeout", 32'(timeout_o), 32'd0);
        rst = 1'b0;
        drive(idle);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-control scoreboard between the decode stage and the execute stage.
- Tracks which of the 32 general registers have an in-flight write. Holds decode (stall) on RAW or WAW hazards, or when execute is not ready.
- Releases a register when its write-back retires. Also provides flush handling and a stall watchdog for the pipeline controller.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is never tracked.
- ADDR_W, 5, register address width.
- CNT_W, 8, width of the stall-cycle counter.
- STALL_LIMIT, 200, consecutive hazard-stall cycles after which timeout_o is set.
- WB_BYPASS, 1, if 1, a source matching this cycle's write-back is treated as ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  decode holds a valid instruction.
- id_reg1_read_i  in  1  instruction reads source 1.
- id_reg1_addr_i  in  ADDR_W  source 1 register.
- id_reg2_read_i  in  1  instruction reads source 2.
- id_reg2_addr_i  in  ADDR_W  source 2 register.
- id_wreg_i  in  1  instruction writes a destination.
- id_wd_i  in  ADDR_W  destination register.
- ex_ready_i  in  1  execute stage can accept an instruction this cycle.
- wb_we_i  in  1  write-back retiring a register write this cycle.
- wb_wd_i  in  ADDR_W  register being written back.
- flush_i  in  1  pipeline flush; discards all in-flight writes.
- issue_o  out  1  decode instruction advances to execute this cycle.
- stall_o  out  1  hold the decode stage and PC.
- busy_o  out  REG_NUM  registered pending-write bitmap (bit n = register n).
- pending_cnt_o  out  ADDR_W+1  registered population count of busy_o.
- stall_cycles_o  out  CNT_W  consecutive hazard-stall cycle count.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset: busy_o=0, pending_cnt_o=0, stall_cycles_o=0, timeout_o=0. issue_o and stall_o are combinational and are 0 while rst=1.
- Ready(a) = (a==0) or !busy[a] or (WB_BYPASS and wb_we_i and wb_wd_i==a).
- hazard = (id_reg1_read_i and !Ready(reg1)) or (id_reg2_read_i and !Ready(reg2)) or (id_wreg_i and id_wd_i!=0 and busy[id_wd_i] and !(wb_we_i and wb_wd_i==id_wd_i)).
- issue_o = id_valid_i and !hazard and ex_ready_i and !flush_i. Zero latency: combinational on the same cycle.
- stall_o = id_valid_i and !issue_o and !flush_i.
- Busy update at the clock edge, in priority order:
  - flush_i: all bits cleared.
  - Otherwise, the wb_we_i clear of bit wb_wd_i is applied first.
  - Then the issue_o and id_wreg_i set of bit id_wd_i is applied.
  - Same register cleared and set in one cycle: the bit ends at 1.
  - Writes to address 0 are never recorded.
  - A write-back to a non-busy register has no effect.
- pending_cnt_o is recomputed from the next busy value, so it is always consistent with busy_o.
- Watchdog (two-state: RUN, TIMEOUT):
  - stall_cycles_o increments, saturating at 2^CNT_W-1, in each cycle where stall_o=1 and hazard=1.
  - It clears to 0 on issue_o, flush_i, or id_valid_i=0.
  - Stalls caused only by ex_ready_i=0 hold the count.
  - RUN->TIMEOUT when the incremented count equals STALL_LIMIT; timeout_o=1.
  - TIMEOUT->RUN only on flush_i or rst. Issuing continues normally while in TIMEOUT.
- flush_i has priority over issue in the same cycle: the instruction is not issued and is not recorded.
- rst mid-operation: all state returns to reset values on the next edge regardless of other inputs.

Test Plan:
- Reset, then issue write to r3 with ex_ready=1 -> issue_o=1; next cycle busy_o=0x0000_0008, pending_cnt_o=1.
- r3 busy; decode reads r3 as source 1 -> stall_o=1 and issue_o=0 for each cycle until wb_we=1, wb_wd=3.
  - In the write-back cycle: issue_o=1 (WB_BYPASS=1).
  - stall_cycles_o counts 1,2,3… and then returns to 0.
- Same cycle: wb retires r5, decode issues a new write to r5 -> busy bit 5 remains 1, pending_cnt_o unchanged.
- Decode writes/reads r0 repeatedly -> never stalls, busy_o bit 0 always 0.
- Set r1, r2, r7 busy, then assert flush_i together with a valid issue -> issue_o=0; next cycle busy_o=0, pending_cnt_o=0.
- Hold hazard on r9 for 200 cycles (STALL_LIMIT=200) -> timeout_o=1 after cycle 200.
  - timeout_o stays 1 after r9 retires.
  - timeout_o clears only after flush_i.
